// File: rtl/spu_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-store read port, decode handshake and odd-pipe redirect.
interface spu_fetch_unit_if #(
  parameter int IMEM_AW = 11
);
  logic               imem_en;
  logic [0:IMEM_AW-1] imem_addr;
  logic [0:63]        imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [0:31]        out_instr0;
  logic [0:31]        out_instr1;
  logic               out_v0;
  logic               out_v1;
  logic [0:31]        out_pc;
  logic               branch_taken;
  logic [0:31]        PC_out;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output out_valid, out_instr0, out_instr1, out_v0, out_v1, out_pc,
    input  out_ready,
    input  branch_taken, PC_out
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  out_valid, out_instr0, out_instr1, out_v0, out_v1, out_pc,
    output out_ready,
    output branch_taken, PC_out
  );
endinterface

// File: rtl/spu_fetch_unit.sv
// SPU fetch stage: reads aligned instruction pairs into a small queue and redirects on branch_taken.
// Optional macro FETCH_BYPASS_EN: a pair returning to an empty queue drives the outputs the same cycle.
module spu_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 11,
  parameter logic [0:31] RESET_PC = 32'h0
) (
  input logic              clk,
  input logic              reset,
  spu_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIRECT} state_t;

  state_t        state_reg, state_next;
  logic [0:31]   fetch_pc_reg;
  logic [0:31]   target_reg;
  logic          odd_reg;
  logic          epoch_reg;
  logic          inflight_reg;
  logic          inflight_epoch_reg;
  logic          inflight_v0_reg;
  logic [0:31]   inflight_pc_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] head_reg, tail_reg;

  logic [0:31]   q_instr0 [DEPTH];
  logic [0:31]   q_instr1 [DEPTH];
  logic [0:31]   q_pc     [DEPTH];
  logic          q_v0     [DEPTH];

  logic flush, data_ok, bypass_sel, issue, valid_int, handshake, push, pop;
  logic unused_target_bits;

  assign unused_target_bits = ^target_reg[30:31];

  assign flush   = bus.branch_taken && (state_reg != S_IDLE);
  // Reads launched before the last redirect carry a stale epoch and are dropped on return.
  assign data_ok = inflight_reg && (inflight_epoch_reg == epoch_reg);

`ifdef FETCH_BYPASS_EN
  assign bypass_sel = data_ok && (count_reg == '0);
`else
  assign bypass_sel = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    valid_int  = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_RUN;
      S_RUN: begin
        issue     = (count_reg + CW'(inflight_reg)) < CW'(DEPTH);
        valid_int = (count_reg != '0) || bypass_sel;
        if (bus.branch_taken) state_next = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (!bus.branch_taken) state_next = S_RUN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign handshake = valid_int && bus.out_ready && !flush;
  assign pop       = handshake && !bypass_sel;
  assign push      = data_ok && !flush && !(bypass_sel && handshake);

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc_reg[29-IMEM_AW:28];
  assign bus.out_valid = valid_int;
  assign bus.out_v1    = valid_int;

  // Slot data is forced to zero whenever nothing is being offered.
  always_comb begin
    bus.out_instr0 = '0;
    bus.out_instr1 = '0;
    bus.out_pc     = '0;
    bus.out_v0     = 1'b0;
    if (valid_int) begin
      if (bypass_sel) begin
        bus.out_instr0 = bus.imem_rdata[0:31];
        bus.out_instr1 = bus.imem_rdata[32:63];
        bus.out_pc     = inflight_pc_reg;
        bus.out_v0     = inflight_v0_reg;
      end else begin
        bus.out_instr0 = q_instr0[head_reg];
        bus.out_instr1 = q_instr1[head_reg];
        bus.out_pc     = q_pc[head_reg];
        bus.out_v0     = q_v0[head_reg];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg       <= RESET_PC;
      target_reg         <= '0;
      odd_reg            <= 1'b0;
      epoch_reg          <= 1'b0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      inflight_v0_reg    <= 1'b0;
      inflight_pc_reg    <= '0;
      count_reg          <= '0;
      head_reg           <= '0;
      tail_reg           <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        fetch_pc_reg       <= fetch_pc_reg + 32'd8;
        inflight_pc_reg    <= fetch_pc_reg;
        inflight_epoch_reg <= epoch_reg;
        inflight_v0_reg    <= !odd_reg;
        odd_reg            <= 1'b0;
      end
      // An odd-word target still fetches the whole aligned pair; slot 0 is marked invalid.
      if (state_reg == S_REDIRECT) begin
        fetch_pc_reg <= {target_reg[0:28], 3'b000};
        odd_reg      <= target_reg[29];
      end
      if (flush) begin
        target_reg <= bus.PC_out;
        epoch_reg  <= ~epoch_reg;
        count_reg  <= '0;
        head_reg   <= '0;
        tail_reg   <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + PW'(1);
        if (pop)  head_reg <= head_reg + PW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr0[tail_reg] <= bus.imem_rdata[0:31];
      q_instr1[tail_reg] <= bus.imem_rdata[32:63];
      q_pc[tail_reg]     <= inflight_pc_reg;
      q_v0[tail_reg]     <= inflight_v0_reg;
    end
  end
endmodule

// File: tb/tb_spu_fetch_unit.sv
// Bench for spu_fetch_unit: startup vector table, scoreboarded pair streams, redirects, reset and wrap.
module tb_spu_fetch_unit;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  spu_fetch_unit_if #(.IMEM_AW(11)) bus ();
  spu_fetch_unit_if #(.IMEM_AW(4))  wbus ();

  spu_fetch_unit #(.DEPTH(4), .IMEM_AW(11), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  spu_fetch_unit #(.DEPTH(4), .IMEM_AW(4), .RESET_PC(32'h0)) dut_w (
    .clk(clk), .reset(reset), .bus(wbus.master)
  );

  // Instruction stores: word i holds i, pair a holds words 2a and 2a+1.
  always @(posedge clk) begin
    if (bus.imem_en)  bus.imem_rdata  <= {20'd0, bus.imem_addr, 1'b0, 20'd0, bus.imem_addr, 1'b1};
    if (wbus.imem_en) wbus.imem_rdata <= {27'd0, wbus.imem_addr, 1'b0, 27'd0, wbus.imem_addr, 1'b1};
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        v0;
  } exp_t;
  exp_t sb[$];

  task automatic expect_pair(input logic [31:0] pc, input logic v0);
    exp_t e;
    e.pc = pc;
    e.i0 = pc >> 2;
    e.i1 = (pc >> 2) + 32'd1;
    e.v0 = v0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && !bus.branch_taken && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("pair pc=%08h i0=%0d i1=%0d v0=%0b v1=%0b", bus.out_pc, bus.out_instr0,
               bus.out_instr1, bus.out_v0, bus.out_v1);
      check("sb_pc", bus.out_pc, e.pc);
      if (e.v0) check("sb_i0", bus.out_instr0, e.i0);
      check("sb_i1", bus.out_instr1, e.i1);
      check("sb_v0", bus.out_v0, e.v0);
      check("sb_v1", bus.out_v1, 1'b1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_en", bus.imem_en, 1'b0);
    check("rst_v0", bus.out_v0, 1'b0);
    check("rst_v1", bus.out_v1, 1'b0);
    check("rst_i0", bus.out_instr0, 32'h0);
    check("rst_i1", bus.out_instr1, 32'h0);
    check("rst_pc", bus.out_pc, 32'h0);
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() > 0; k++) next_cycle();
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  typedef struct {
    logic        ready;
    logic        exp_en;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_i0;
    logic [31:0] exp_i1;
  } vec_t;
  vec_t vecs [7];

  initial begin
    logic found;
    bus.out_ready     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.PC_out        = 32'h0;
    wbus.out_ready    = 1'b1;
    wbus.branch_taken = 1'b0;
    wbus.PC_out       = 32'h0;

    for (int c = 0; c < 7; c++) begin
      vecs[c].ready     = 1'b1;
      vecs[c].exp_en    = (c >= 1);
      vecs[c].exp_valid = (c >= LAT);
      vecs[c].exp_pc    = (c >= LAT) ? 32'((c - LAT) * 8) : 32'h0;
      vecs[c].exp_i0    = (c >= LAT) ? 32'((c - LAT) * 2) : 32'h0;
      vecs[c].exp_i1    = (c >= LAT) ? 32'((c - LAT) * 2 + 1) : 32'h0;
    end

    // Startup: first read at c1, first pair at c3 (c2 with bypass), then one pair per cycle.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = vecs[c].ready;
      @(negedge clk);
      $display("cycle c%0d en=%0b valid=%0b pc=%08h", c, bus.imem_en, bus.out_valid, bus.out_pc);
      check($sformatf("vec%0d_en", c), bus.imem_en, vecs[c].exp_en);
      check($sformatf("vec%0d_valid", c), bus.out_valid, vecs[c].exp_valid);
      if (vecs[c].exp_valid) begin
        check($sformatf("vec%0d_pc", c), bus.out_pc, vecs[c].exp_pc);
        check($sformatf("vec%0d_i0", c), bus.out_instr0, vecs[c].exp_i0);
        check($sformatf("vec%0d_i1", c), bus.out_instr1, vecs[c].exp_i1);
        check($sformatf("vec%0d_v0", c), bus.out_v0, 1'b1);
        check($sformatf("vec%0d_v1", c), bus.out_v1, 1'b1);
      end
      next_cycle();
    end

    // Stall: queue fills to DEPTH, reads stop, then drains in order.
    do_reset();
    bus.out_ready = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    check("stall_en", bus.imem_en, 1'b0);
    check("stall_valid", bus.out_valid, 1'b1);
    check("stall_pc", bus.out_pc, 32'h0);
    next_cycle();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) expect_pair(32'(k * 8), 1'b1);
    @(negedge clk);
    check("full_en", bus.imem_en, 1'b0);
    next_cycle();
    @(negedge clk);
    check("refill_en", bus.imem_en, 1'b1);
    drain("drain_stall");

    // Redirect to 0x40 with data returning and a read issuing in the branch cycle.
    do_reset();
    bus.out_ready = 1'b0;
    repeat (4) next_cycle();
    bus.branch_taken = 1'b1;
    bus.PC_out       = 32'h40;
    next_cycle();
    bus.branch_taken = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("redir_bubble%0d", k), bus.out_valid, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    check("redir_valid", bus.out_valid, 1'b1);
    check("redir_pc", bus.out_pc, 32'h40);
    check("redir_i0", bus.out_instr0, 32'd16);
    check("redir_i1", bus.out_instr1, 32'd17);
    expect_pair(32'h40, 1'b1);
    expect_pair(32'h48, 1'b1);
    expect_pair(32'h50, 1'b1);
    next_cycle();
    bus.out_ready = 1'b1;
    drain("drain_redir40");

    // Odd-word target while streaming.
    bus.branch_taken = 1'b1;
    bus.PC_out       = 32'h44;
    expect_pair(32'h40, 1'b0);
    expect_pair(32'h48, 1'b1);
    expect_pair(32'h50, 1'b1);
    next_cycle();
    bus.branch_taken = 1'b0;
    drain("drain_odd44");

    // Back-to-back redirects: only the later target is delivered.
    bus.branch_taken = 1'b1;
    bus.PC_out       = 32'h80;
    next_cycle();
    bus.PC_out = 32'h100;
    expect_pair(32'h100, 1'b1);
    expect_pair(32'h108, 1'b1);
    expect_pair(32'h110, 1'b1);
    next_cycle();
    bus.branch_taken = 1'b0;
    drain("drain_b2b");

    // Reset mid-operation, then address wrap on the 4-bit store.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (wbus.imem_en && wbus.imem_addr == 4'd15) found = 1'b1;
      next_cycle();
    end
    check("wrap_addr15_seen", found, 1'b1);
    @(negedge clk);
    check("wrap_addr0", wbus.imem_addr, 4'd0);
    check("wrap_en", wbus.imem_en, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (wbus.out_valid && wbus.out_pc == 32'h78) found = 1'b1;
      else @(negedge clk);
    end
    check("wrap_pc78_seen", found, 1'b1);
    @(negedge clk);
    check("wrap_valid", wbus.out_valid, 1'b1);
    check("wrap_pc80", wbus.out_pc, 32'h80);
    check("wrap_i0", wbus.out_instr0, 32'd0);
    check("wrap_i1", wbus.out_instr1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
